// File: rtl/demux_sched.sv
// Scheduler for a 1-to-2 demux: pops a show-ahead source FIFO and steers each
// word to lane 0 or 1 with a one-cycle registered push, honouring almost-full.
module demux_sched #(
   parameter int DATA_SIZE = 4,
   parameter int SEL_BIT   = 3,
   parameter int CNT_W     = 5
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic                 enable,
   input  logic                 rr_mode,
   input  logic                 fifo_empty,
   input  logic [DATA_SIZE-1:0] fifo_data,
   input  logic                 almost_full0,
   input  logic                 almost_full1,
   output logic                 pop,
   output logic                 push0,
   output logic                 push1,
   output logic [DATA_SIZE-1:0] data_out0,
   output logic [DATA_SIZE-1:0] data_out1,
   output logic [CNT_W-1:0]     count0,
   output logic [CNT_W-1:0]     count1,
   output logic                 idle
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_STALL  = 2'd2
   } state_t;

   state_t state_q;
   logic   idle_q;
   logic   rr_q;
   logic   rr_d;
   logic   dest;
   logic   blocked;

   // Lane choice is head-of-line: a blocked lane stalls everything behind it.
   always_comb begin
      dest    = rr_mode ? rr_q : fifo_data[SEL_BIT];
      blocked = dest ? almost_full1 : almost_full0;
      pop     = enable & ~fifo_empty & ~blocked & (state_q != S_IDLE);
      rr_d    = (pop && rr_mode) ? ~rr_q : rr_q;
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= S_IDLE;
         idle_q  <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (enable && !fifo_empty) begin
                  state_q <= S_ACTIVE;
                  idle_q  <= 1'b0;
               end
            end
            S_ACTIVE: begin
               if (fifo_empty || !enable) begin
                  state_q <= S_IDLE;
                  idle_q  <= 1'b1;
               end else if (blocked) begin
                  state_q <= S_STALL;
               end
            end
            S_STALL: begin
               // Leaving STALL pops in the same cycle the block clears.
               if (!enable || fifo_empty) begin
                  state_q <= S_IDLE;
                  idle_q  <= 1'b1;
               end else if (!blocked) begin
                  state_q <= S_ACTIVE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               idle_q  <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      localparam logic LANE = 1'(gi);

      logic                 sel;
      logic                 push_q;
      logic [DATA_SIZE-1:0] data_q;
      logic [DATA_SIZE-1:0] data_d;
      logic [CNT_W-1:0]     cnt_q;
      logic [CNT_W-1:0]     cnt_d;

      always_comb begin
         sel    = pop && (dest == LANE);
         data_d = sel ? fifo_data : data_q;
         cnt_d  = sel ? cnt_q + CNT_W'(1) : cnt_q;
      end

      always_ff @(posedge clk or negedge reset_L) begin
         if (!reset_L) begin
            push_q <= 1'b0;
            data_q <= '0;
            cnt_q  <= '0;
         end else begin
            push_q <= sel;
            data_q <= data_d;
            cnt_q  <= cnt_d;
         end
      end
   end

   assign push0     = g_lane[0].push_q;
   assign push1     = g_lane[1].push_q;
   assign data_out0 = g_lane[0].data_q;
   assign data_out1 = g_lane[1].data_q;
   assign count0    = g_lane[0].cnt_q;
   assign count1    = g_lane[1].cnt_q;
   assign idle      = idle_q;

endmodule

// File: tb/tb_demux_sched.sv
// Directed bench for demux_sched with a queue-based show-ahead FIFO model.
module tb_demux_sched;

   logic       clk = 1'b0;
   logic       reset_L;
   logic       enable;
   logic       rr_mode;
   logic       fifo_empty;
   logic [3:0] fifo_data;
   logic       almost_full0;
   logic       almost_full1;
   logic       pop;
   logic       push0;
   logic       push1;
   logic [3:0] data_out0;
   logic [3:0] data_out1;
   logic [4:0] count0;
   logic [4:0] count1;
   logic       idle;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [3:0] fifo_q[$];
   logic       pop_seen;

   demux_sched #(.DATA_SIZE(4), .SEL_BIT(3), .CNT_W(5)) dut (
      .clk          (clk),
      .reset_L      (reset_L),
      .enable       (enable),
      .rr_mode      (rr_mode),
      .fifo_empty   (fifo_empty),
      .fifo_data    (fifo_data),
      .almost_full0 (almost_full0),
      .almost_full1 (almost_full1),
      .pop          (pop),
      .push0        (push0),
      .push1        (push1),
      .data_out0    (data_out0),
      .data_out1    (data_out1),
      .count0       (count0),
      .count1       (count1),
      .idle         (idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_fifo();
      fifo_empty = (fifo_q.size() == 0);
      fifo_data  = (fifo_q.size() == 0) ? 4'h0 : fifo_q[0];
   endtask

   // One clock: sample pop before the edge, retire the popped word after it.
   task automatic cyc();
      #1;
      pop_seen = pop;
      @(posedge clk);
      #1;
      if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      drive_fifo();
      #1;
   endtask

   task automatic load(input logic [3:0] w);
      fifo_q.push_back(w);
      drive_fifo();
   endtask

   logic [3:0] t2_data [4] = '{4'h9, 4'h2, 4'hA, 4'h3};
   logic       t2_lane [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      reset_L      = 1'b0;
      enable       = 1'b0;
      rr_mode      = 1'b0;
      almost_full0 = 1'b0;
      almost_full1 = 1'b0;
      drive_fifo();
      cyc();
      cyc();
      chk("rst_pop", pop, 0);
      chk("rst_idle", idle, 1);
      chk("rst_push0", push0, 0);
      chk("rst_push1", push1, 0);
      chk("rst_cnt0", count0, 0);
      chk("rst_cnt1", count1, 0);
      reset_L = 1'b1;
      enable  = 1'b1;
      #1;

      // Empty source: scheduler never leaves IDLE
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("empty_pop%0d", i), pop, 0);
         cyc();
         chk($sformatf("empty_idle%0d", i), idle, 1);
         chk($sformatf("empty_push%0d", i), {push1, push0}, 0);
      end

      // Class routing on bit 3
      for (int i = 0; i < 4; i++) load(t2_data[i]);
      #1;
      chk("cls_idle_nopop", pop, 0);
      cyc();
      chk("cls_active", idle, 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("cls_pop%0d", i), pop, 1);
         cyc();
         chk($sformatf("cls_push0_%0d", i), push0, !t2_lane[i]);
         chk($sformatf("cls_push1_%0d", i), push1, t2_lane[i]);
         if (t2_lane[i]) chk($sformatf("cls_d1_%0d", i), data_out1, t2_data[i]);
         else            chk($sformatf("cls_d0_%0d", i), data_out0, t2_data[i]);
      end
      chk("cls_drain_pop", pop, 0);
      cyc();
      chk("cls_push_off", {push1, push0}, 0);
      chk("cls_idle", idle, 1);
      chk("cls_cnt0", count0, 2);
      chk("cls_cnt1", count1, 2);

      // Round-robin routing
      rr_mode = 1'b1;
      for (int i = 1; i <= 6; i++) load(4'(i));
      cyc();
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("rr_pop%0d", i), pop, 1);
         cyc();
         chk($sformatf("rr_lane%0d", i), {push1, push0}, (i % 2 == 0) ? 2'b01 : 2'b10);
         if (i % 2 == 0) chk($sformatf("rr_d0_%0d", i), data_out0, i + 1);
         else            chk($sformatf("rr_d1_%0d", i), data_out1, i + 1);
      end
      chk("rr_cnt0", count0, 5);
      chk("rr_cnt1", count1, 5);
      cyc();
      chk("rr_idle", idle, 1);

      // Backpressure stall on lane 1
      rr_mode      = 1'b0;
      almost_full1 = 1'b1;
      load(4'h8);
      cyc();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall_pop%0d", i), pop, 0);
         cyc();
         chk($sformatf("stall_push%0d", i), {push1, push0}, 0);
         chk($sformatf("stall_busy%0d", i), idle, 0);
      end
      almost_full1 = 1'b0;
      #1;
      chk("stall_release_pop", pop, 1);
      cyc();
      chk("stall_push", {push1, push0}, 2'b10);
      chk("stall_d1", data_out1, 8);
      chk("stall_cnt1", count1, 6);
      cyc();
      chk("stall_idle", idle, 1);

      // Asynchronous reset with a push in flight
      load(4'h4);
      load(4'h5);
      cyc();
      chk("mrst_pop", pop, 1);
      cyc();
      chk("mrst_pending", push0, 1);
      reset_L = 1'b0;
      #1;
      chk("mrst_push", {push1, push0}, 0);
      chk("mrst_d0", data_out0, 0);
      chk("mrst_d1", data_out1, 0);
      chk("mrst_cnt0", count0, 0);
      chk("mrst_cnt1", count1, 0);
      chk("mrst_idle", idle, 1);
      chk("mrst_pop0", pop, 0);
      cyc();
      reset_L = 1'b1;
      #1;
      chk("mrst_after_pop", pop, 0);
      cyc();
      chk("mrst_reactive", idle, 0);
      chk("mrst_repop", pop, 1);
      cyc();
      chk("mrst_push5", push0, 1);
      chk("mrst_d0_5", data_out0, 5);
      chk("mrst_cnt0_1", count0, 1);
      cyc();

      // Counter wrap on lane 0
      reset_L = 1'b0;
      cyc();
      reset_L = 1'b1;
      #1;
      for (int i = 0; i < 33; i++) load(4'(i % 8));
      cyc();
      for (int i = 0; i < 33; i++) begin
         cyc();
         if (i == 30) chk("wrap_cnt31", count0, 31);
         if (i == 31) chk("wrap_cnt0", count0, 0);
         if (i == 32) begin
            chk("wrap_cnt1", count0, 1);
            chk("wrap_d0", data_out0, 0);
            chk("wrap_lane1_cnt", count1, 0);
         end
      end
      cyc();
      chk("wrap_idle", idle, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
